// File: rtl/mode_ctrl_if.sv
// Switch, vsync and hot-plug signals between the board/sink side and mode_ctrl.
// Latency: none (wires only).
// Backpressure: none; level and pulse signals, no handshake.
interface mode_ctrl_if;
    logic [3:0] sw_i;
    logic       vs_i;
    logic       vout_hpd_i;
    logic       ld_o;
    logic       dl_o;
    logic       src_sel_o;
    logic       commit_o;
    logic       vin_hpd_o;
    logic [1:0] hpd_state_o;

    modport master (
        output sw_i, vs_i, vout_hpd_i,
        input  ld_o, dl_o, src_sel_o, commit_o, vin_hpd_o, hpd_state_o
    );

    modport slave (
        input  sw_i, vs_i, vout_hpd_i,
        output ld_o, dl_o, src_sel_o, commit_o, vin_hpd_o, hpd_state_o
    );
endinterface

// File: rtl/mode_ctrl.sv
// Frame-synchronous mode commit and source hot-plug sequencer (FANTASY_HPD_REPLUG_EN: replug on source change).
// Latency: commit on the edge sampling a vs rise; HPD rises 2+1+HPD_DLY+1 cycles after request.
// Backpressure: none; inputs are levels, outputs are registered levels plus a one-cycle commit pulse.
module mode_ctrl #(
    parameter int DEB_BITS     = 20,
    parameter int HPD_DLY      = 1000000,
    parameter int HPD_LOW      = 2000000,
    parameter int TIMEOUT_BITS = 24
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    mode_ctrl_if.slave io
);

    localparam int TMAX = (HPD_DLY > HPD_LOW) ? HPD_DLY : HPD_LOW;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] DLY_LD = TW'(HPD_DLY);
    localparam logic [TW-1:0] LOW_LD = TW'(HPD_LOW);

    typedef enum logic [1:0] {
        HPD_OFF    = 2'd0,
        HPD_WAIT   = 2'd1,
        HPD_ON     = 2'd2,
        HPD_REPLUG = 2'd3
    } hpd_st_t;

    logic [3:0]              sw_s1, sw_s2;
    logic                    hpd_s1, hpd_s2;
    logic [3:0]              deb;
    logic [DEB_BITS-1:0]     deb_cnt [4];
    logic                    vs_prev;
    logic [TIMEOUT_BITS-1:0] wd_cnt;
    logic [2:0]              cmt;
    logic                    commit_q;
    hpd_st_t                 st;
    logic [TW-1:0]           tmr;
    logic                    vin_hpd_q;

    logic vs_rise;
    logic wd_sat;
    logic do_commit;
    logic want;
    logic replug_trig;

    assign vs_rise   = io.vs_i & ~vs_prev;
    assign wd_sat    = &wd_cnt;
    assign do_commit = (vs_rise | wd_sat) & (deb[2:0] != cmt);
    assign want      = hpd_s2 | deb[3];

`ifdef FANTASY_HPD_REPLUG_EN
    assign replug_trig = do_commit & (deb[2] != cmt[2]);
`else
    assign replug_trig = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            hpd_s1 <= 1'b0;
            hpd_s2 <= 1'b0;
        end else begin
            sw_s1  <= io.sw_i;
            sw_s2  <= sw_s1;
            hpd_s1 <= io.vout_hpd_i;
            hpd_s2 <= hpd_s1;
        end
    end

    // A bit flips only after 2^DEB_BITS consecutive cycles of disagreement.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            deb <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sw_s2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (&deb_cnt[i]) begin
                    deb[i]     <= sw_s2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vs_prev  <= 1'b0;
            wd_cnt   <= '0;
            cmt      <= '0;
            commit_q <= 1'b0;
        end else begin
            vs_prev  <= io.vs_i;
            commit_q <= do_commit;
            if (vs_rise)
                wd_cnt <= '0;
            else if (!wd_sat)
                wd_cnt <= wd_cnt + TIMEOUT_BITS'(1);
            if (do_commit)
                cmt <= deb[2:0];
        end
    end

    // Loss of want is checked first in every state so it beats a replug.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st        <= HPD_OFF;
            tmr       <= '0;
            vin_hpd_q <= 1'b0;
        end else begin
            case (st)
                HPD_OFF: begin
                    vin_hpd_q <= 1'b0;
                    if (want) begin
                        tmr <= DLY_LD;
                        st  <= HPD_WAIT;
                    end
                end
                HPD_WAIT: begin
                    if (!want) begin
                        st <= HPD_OFF;
                    end else if (tmr == '0) begin
                        st        <= HPD_ON;
                        vin_hpd_q <= 1'b1;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                HPD_ON: begin
                    if (!want) begin
                        st        <= HPD_OFF;
                        vin_hpd_q <= 1'b0;
                    end else if (replug_trig) begin
                        tmr       <= LOW_LD;
                        st        <= HPD_REPLUG;
                        vin_hpd_q <= 1'b0;
                    end
                end
                HPD_REPLUG: begin
                    if (!want) begin
                        st <= HPD_OFF;
                    end else if (tmr == '0) begin
                        tmr <= DLY_LD;
                        st  <= HPD_WAIT;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                default: begin
                    st        <= HPD_OFF;
                    vin_hpd_q <= 1'b0;
                end
            endcase
        end
    end

    assign io.ld_o        = cmt[0];
    assign io.dl_o        = cmt[1];
    assign io.src_sel_o   = cmt[2];
    assign io.commit_o    = commit_q;
    assign io.vin_hpd_o   = vin_hpd_q;
    assign io.hpd_state_o = st;

endmodule

// File: tb/tb_mode_ctrl.sv
// Directed bench for mode_ctrl: reset, HPD sequencing, debounce/commit, watchdog, replug, async reset.
module tb_mode_ctrl;

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   pulses;
    int   low_cnt;
    logic s0, s1;

`ifdef FANTASY_HPD_REPLUG_EN
    localparam bit RP = 1'b1;
`else
    localparam bit RP = 1'b0;
`endif

    mode_ctrl_if io ();

    mode_ctrl #(
        .DEB_BITS    (3),
        .HPD_DLY     (4),
        .HPD_LOW     (8),
        .TIMEOUT_BITS(6)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ld"},     32'(io.ld_o),        32'd0);
        chk({tag, "_dl"},     32'(io.dl_o),        32'd0);
        chk({tag, "_src"},    32'(io.src_sel_o),   32'd0);
        chk({tag, "_commit"}, 32'(io.commit_o),    32'd0);
        chk({tag, "_vin"},    32'(io.vin_hpd_o),   32'd0);
        chk({tag, "_state"},  32'(io.hpd_state_o), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        chk_zero(tag);
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    // HPD up, then a source change committed at the vs rise sampled on edge 40.
    task automatic replug_pass(input int stop_at);
        low_cnt       = 0;
        pulses        = 0;
        io.sw_i       = 4'b0000;
        io.vs_i       = 1'b0;
        io.vout_hpd_i = 1'b0;
        do_reset("rp_rst");
        for (int d = 0; d < stop_at; d++) begin
            io.vout_hpd_i = 1'b1;
            io.sw_i       = (d >= 10) ? 4'b0100 : 4'b0000;
            io.vs_i       = (d >= 40) && (d < 50);
            cyc();
            if (io.commit_o) pulses++;
            if (d >= 40 && !io.vin_hpd_o) low_cnt++;
            if (d == 39) begin
                chk("rp_pre_vin",   32'(io.vin_hpd_o),   32'd1);
                chk("rp_pre_state", 32'(io.hpd_state_o), 32'd2);
                chk("rp_pre_src",   32'(io.src_sel_o),   32'd0);
            end
            if (d == 40) begin
                chk("rp_src",    32'(io.src_sel_o),   32'd1);
                chk("rp_commit", 32'(io.commit_o),    32'd1);
                chk("rp_vin_lo", 32'(io.vin_hpd_o),   RP ? 32'd0 : 32'd1);
                chk("rp_state",  32'(io.hpd_state_o), RP ? 32'd3 : 32'd2);
            end
            if (d == 48) chk("rp_state_end",   32'(io.hpd_state_o), RP ? 32'd3 : 32'd2);
            if (d == 49) chk("rp_state_wait",  32'(io.hpd_state_o), RP ? 32'd1 : 32'd2);
            if (d == 53) chk("rp_vin_waitend", 32'(io.vin_hpd_o),   RP ? 32'd0 : 32'd1);
            if (d == 54) begin
                chk("rp_vin_back",   32'(io.vin_hpd_o),   32'd1);
                chk("rp_state_back", 32'(io.hpd_state_o), 32'd2);
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        io.sw_i       = 4'b0000;
        io.vs_i       = 1'b0;
        io.vout_hpd_i = 1'b0;
        #2;
        chk_zero("rst_hold");
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        chk_zero("rst_rel");

        // HPD rise: 2 sync + 1 + HPD_DLY + 1 = 8 edges
        io.vout_hpd_i = 1'b1;
        cyc();
        cyc();
        chk("hpd_sync_state", 32'(io.hpd_state_o), 32'd0);
        cyc();
        chk("hpd_wait_state", 32'(io.hpd_state_o), 32'd1);
        repeat (4) cyc();
        chk("hpd_vin_edge7",   32'(io.vin_hpd_o),   32'd0);
        chk("hpd_state_edge7", 32'(io.hpd_state_o), 32'd1);
        cyc();
        chk("hpd_vin_edge8",   32'(io.vin_hpd_o),   32'd1);
        chk("hpd_state_edge8", 32'(io.hpd_state_o), 32'd2);

        io.vout_hpd_i = 1'b0;
        cyc();
        cyc();
        chk("hpd_drop_edge2", 32'(io.vin_hpd_o), 32'd1);
        cyc();
        chk("hpd_drop_vin",   32'(io.vin_hpd_o),   32'd0);
        chk("hpd_drop_state", 32'(io.hpd_state_o), 32'd0);

        // Debounce + vs commit (c < 80), then watchdog commit with vs held low
        pulses = 0;
        for (int c = 0; c < 140; c++) begin
            s0      = (c < 40) ? ((c / 4) % 2 == 0) : 1'b1;
            s1      = (c >= 80);
            io.sw_i = {2'b00, s1, s0};
            io.vs_i = (c < 80) && (c % 30 < 15);
            cyc();
            if (io.commit_o) pulses++;
            if (c == 59) begin
                chk("deb_ld_before",  32'(io.ld_o), 32'd0);
                chk("deb_no_toggle_commit", 32'(pulses), 32'd0);
            end
            if (c == 60) begin
                chk("deb_ld_commit", 32'(io.ld_o),     32'd1);
                chk("deb_pulse",     32'(io.commit_o), 32'd1);
            end
            if (c == 61) chk("deb_pulse_end", 32'(io.commit_o), 32'd0);
            if (c == 79) chk("deb_one_pulse", 32'(pulses), 32'd1);
            if (c == 123) chk("wd_dl_before", 32'(io.dl_o), 32'd0);
            if (c == 124) begin
                chk("wd_dl_commit", 32'(io.dl_o),     32'd1);
                chk("wd_pulse",     32'(io.commit_o), 32'd1);
                chk("wd_ld_kept",   32'(io.ld_o),     32'd1);
            end
            if (c == 139) begin
                chk("wd_total_pulses", 32'(pulses), 32'd2);
                chk("wd_dl_hold",      32'(io.dl_o), 32'd1);
            end
        end

        replug_pass(80);
        chk("rp_low_cycles", 32'(low_cnt), RP ? 32'd14 : 32'd0);
        chk("rp_pulses",     32'(pulses),  32'd1);

        // Stop inside REPLUG (edge 44) and hit reset between clock edges
        replug_pass(45);
        chk("mid_src_before", 32'(io.src_sel_o), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_vin",   32'(io.vin_hpd_o),   32'd0);
        chk("mid_rst_src",   32'(io.src_sel_o),   32'd0);
        chk("mid_rst_state", 32'(io.hpd_state_o), 32'd0);
        cyc();
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
